// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types for the serial compare sequencer and its comparator
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

  localparam cmp_result_t RESULT_EQ = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

  function automatic cmp_result_t to_result(input cmp_state_t s);
    cmp_result_t r;
    r.lt = (s == CMP_LT);
    r.gt = (s == CMP_GT);
    r.eq = (s == CMP_EQ);
    return r;
  endfunction

endpackage

// File: rtl/serial_comparator_most_significant_first_using_fsm.sv
// rtl/serial_comparator_most_significant_first_using_fsm.sv - MSB-first bit-serial magnitude comparator
module serial_comparator_most_significant_first_using_fsm
  import serial_cmp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);

  cmp_state_t  state_q;
  cmp_state_t  state_d;
  cmp_result_t res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CMP_EQ;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Once a difference is seen at a more significant bit, lower bits cannot change the verdict.
  always_comb begin
    state_d = state_q;
    if (state_q == CMP_EQ) begin
      if (a && !b) begin
        state_d = CMP_GT;
      end else if (!a && b) begin
        state_d = CMP_LT;
      end
    end
  end

  assign res = to_result(state_d);
  assign lt  = res.lt;
  assign eq  = res.eq;
  assign gt  = res.gt;

endmodule

// File: rtl/serial_compare_sequencer.sv
// rtl/serial_compare_sequencer.sv - accepts an operand pair, feeds it MSB-first to the serial comparator, holds the result
module serial_compare_sequencer
  import serial_cmp_pkg::*;
#(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_lt,
  output logic                   out_eq,
  output logic                   out_gt,
  output logic [$clog2(W+1)-1:0] bits_used
);

  localparam int CW = $clog2(W + 1);

  seq_state_t  state_q;
  seq_state_t  state_d;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [CW-1:0] cnt;
  cmp_result_t result_q;
  logic [CW-1:0] bits_q;

  cmp_result_t cmp_res;
  logic        cmp_rst;
  logic        last_bit;
  logic        shift_exit;
  logic        accept;

  // The comparator is cleared whenever no compare is in flight so each pair starts at "equal".
  assign cmp_rst = rst | (state_q == ST_IDLE) | flush;

  serial_comparator_most_significant_first_using_fsm u_cmp (
    .clk (clk),
    .rst (cmp_rst),
    .en  (state_q == ST_SHIFT),
    .a   (a_sr[W-1]),
    .b   (b_sr[W-1]),
    .lt  (cmp_res.lt),
    .eq  (cmp_res.eq),
    .gt  (cmp_res.gt)
  );

  assign last_bit   = (cnt == CW'(W - 1));
  assign shift_exit = last_bit || (EARLY_EXIT && !cmp_res.eq);
  assign accept     = (state_q == ST_IDLE) && in_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !flush;
        if (accept) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (shift_exit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      cnt      <= '0;
      result_q <= RESULT_EQ;
      bits_q   <= '0;
    end else if (accept) begin
      a_sr <= in_a;
      b_sr <= in_b;
      cnt  <= '0;
    end else if ((state_q == ST_SHIFT) && !flush) begin
      a_sr <= {a_sr[W-2:0], 1'b0};
      b_sr <= {b_sr[W-2:0], 1'b0};
      cnt  <= cnt + CW'(1);
      if (shift_exit) begin
        result_q <= cmp_res;
        bits_q   <= cnt + CW'(1);
      end
    end
  end

  assign out_lt    = result_q.lt;
  assign out_eq    = result_q.eq;
  assign out_gt    = result_q.gt;
  assign bits_used = bits_q;

endmodule

// File: doc/serial_compare_sequencer.md
SERIAL_COMPARE_SEQUENCER -- requirements
Module: serial_compare_sequencer

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 2..32.
REQ-002 Parameter EARLY_EXIT, default 1: 1 ends a compare at the first differing bit; 0 always shifts all W bits.
REQ-003 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high; clock clk.
REQ-005 Port in_valid, input, 1: operand pair offered.
REQ-006 Port in_ready, output, 1: sequencer accepts an operand pair this cycle.
REQ-007 Port in_a, input, W: operand A, unsigned.
REQ-008 Port in_b, input, W: operand B, unsigned.
REQ-009 Port flush, input, 1: synchronous abort of the current compare.
REQ-010 Port out_valid, output, 1: result available.
REQ-011 Port out_ready, input, 1: consumer takes the result.
REQ-012 Port out_lt / out_eq / out_gt, output, 1 each: one-hot result for A<B, A==B and A>B.
REQ-013 Port bits_used, output, $clog2(W+1): number of bit pairs shifted for this result.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, when in_valid is 1, the block SHALL capture in_a/in_b into shift registers, clear the bit counter and go to SHIFT.
REQ-017 In SHIFT, each cycle SHALL present the MSBs of the A/B shift registers to the comparator, then shift both registers left by one bit and increment the counter.
REQ-018 The comparator's synchronous reset SHALL be rst OR (state==IDLE) OR flush, so every compare starts in the equal state.
REQ-019 SHIFT SHALL exit to DONE when counter==W-1, or, with EARLY_EXIT=1, when the comparator's combinational output is not eq.
REQ-020 On that exit the block SHALL register the comparator's lt/eq/gt outputs and counter+1 into the result registers.
REQ-021 Latency: for an accept at edge T, out_valid SHALL rise after edge T+n, where n = bits shifted; n = W for equal operands or EARLY_EXIT=0, otherwise n = W minus the index of the highest differing bit.
REQ-022 In DONE, out_lt/out_eq/out_gt/bits_used SHALL hold stable until out_valid and out_ready are both 1; the block then goes to IDLE.
REQ-023 The block SHALL NOT accept a new pair in the cycle a result is taken, so the minimum accept-to-accept spacing is n+2 cycles.
REQ-024 flush in SHIFT or DONE SHALL force IDLE on the next edge; no out_valid is produced for that pair and the result is discarded.
REQ-025 flush in IDLE SHALL have no effect and SHALL block the accept in that cycle.
REQ-026 flush SHALL have priority over out_ready and over the REQ-019 exit.
REQ-027 Exactly one of out_lt/out_eq/out_gt SHALL be 1 whenever out_valid is 1.

Reset
REQ-028 On rst: state=IDLE, in_ready=1, out_valid=0, out_lt=0, out_eq=1, out_gt=0, bits_used=0, shift registers and counter=0.
REQ-029 rst asserted mid-SHIFT or mid-DONE SHALL discard the transaction with no partial result visible.

Structure
REQ-030 Package serial_cmp_pkg SHALL hold the state enum and a packed result typedef {lt, eq, gt}.
REQ-031 The design SHALL instantiate exactly one serial_comparator_most_significant_first_using_fsm as its sub-module; the comparison itself SHALL NOT be duplicated in the sequencer.

Verification (W=8)
REQ-032 A=0xA5, B=0xA5 -> out_eq=1, bits_used=8, out_valid after edge T+8.
REQ-033 A=0x80, B=0x7F, EARLY_EXIT=1 -> out_gt=1, bits_used=1, out_valid after edge T+1; with EARLY_EXIT=0 -> out_gt=1, bits_used=8.
REQ-034 A=0x12, B=0x13 -> out_lt=1, bits_used=8.
REQ-035 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no accept; release -> IDLE, then the next pair is accepted.
REQ-036 flush, and separately rst, on the 4th SHIFT cycle of A=0x01, B=0x02 -> IDLE next edge, no out_valid; a following pair 0xFF vs 0x00 -> out_gt, bits_used=1.
REQ-037 in_valid held high over 3 back-to-back pairs -> each result is correct and accepts are spaced n+2 cycles apart.
